trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap and return sequencer for the machine-mode CSR file. It owns the CSR file's single read/write port whenever a trap or `mret` is in progress. During a trap it writes `mepc`, `mcause` and `mtval` in sequence, then reads `mtvec` and issues a PC redirect. When idle it passes the pipeline's CSR-instruction accesses straight through to the CSR file.

## Interface
Parameters:
- `XLEN`, 32: data and PC width. Only 32 is supported.

Ports:
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: reset, asynchronous, active-high.
- `i_exc_valid`  in  1: synchronous exception request (1-cycle pulse).
- `i_exc_cause`  in  4: exception cause code.
- `i_exc_pc`  in  32: PC of the faulting instruction.
- `i_exc_tval`  in  32: trap value.
- `i_irq_valid`  in  1: interrupt request, already masked by `mie`/`mstatus`.
- `i_irq_cause`  in  4: interrupt cause code.
- `i_irq_pc`  in  32: PC of the next instruction to be resumed after the interrupt.
- `i_mret`  in  1: `mret` retiring.
- `i_ins_csr_we`, `i_ins_csr_re`  in  1 each: pipeline CSR-instruction write and read enables.
- `i_ins_funct3`  in  4: CSR-instruction funct3, zero-extended.
- `i_ins_csr_addr`  in  12: CSR-instruction address.
- `i_ins_csr_wdata`  in  32: CSR-instruction write data.
- `o_ins_stall`  out  1: CSR-instruction access blocked this cycle.
- `o_csr_addr`  out  12: address driven to the CSR file.
- `o_csr_we`, `o_csr_re`  out  1 each: write and read enables driven to the CSR file.
- `o_csr_funct3`  out  4: funct3 driven to the CSR file.
- `o_csr_data`  out  32: write data driven to the CSR file.
- `i_csr_rdata`  in  32: CSR file read data (combinational).
- `o_redirect`  out  1: one-cycle PC redirect strobe.
- `o_redirect_pc`  out  32: redirect target; registered.
- `o_busy`  out  1: sequencer is not in IDLE.

## Operation
- FSM states: IDLE, W_EPC, W_CAUSE, W_TVAL, RD_VEC, RD_EPC, REDIRECT.
- **IDLE**
  - With no request, the CSR port is a pure pass-through of the `i_ins_*` signals and `o_ins_stall` is 0.
  - Request priority is exception > interrupt > `mret`. Only one request is accepted per cycle; the lower-priority requests in that cycle are dropped.
  - On accepting a trap:
    - latch the PC (`i_exc_pc` or `i_irq_pc`), the cause, the `is_irq` flag, and tval (`i_exc_tval`, or 0 for an interrupt);
    - go to W_EPC.
  - On accepting `mret`, go to RD_EPC.
  - In the accept cycle the pass-through is suppressed (`o_csr_we` = `o_csr_re` = 0) and `o_ins_stall` is 1.
- **Write states** all drive funct3 = 4'b0001 (CSRRW) with `o_csr_we` = 1:
  - W_EPC: address 0x341, data = latched PC with bits [1:0] forced to 0.
  - W_CAUSE: address 0x342, data = {`is_irq`, 27'b0, cause}.
  - W_TVAL: address 0x343, data = latched tval.
- **Read states** drive `o_csr_re` = 1 and register `i_csr_rdata`:
  - RD_VEC: address 0x305; target = {rdata[31:2], 2'b00}.
  - RD_EPC: address 0x341; target = {rdata[31:2], 2'b00}.
- **REDIRECT**: `o_redirect` = 1, `o_redirect_pc` = target; next state is IDLE.
- **In every non-IDLE state**:
  - `o_busy` = 1 and `o_ins_stall` = 1;
  - CSR-port outputs not listed for that state are 0;
  - new requests are ignored, not queued.
- **Reset**, asserted at any time:
  - state goes to IDLE and all latched fields clear;
  - a partially completed sequence is abandoned, with no further writes.

## Timing
- Reset values:
  - `o_redirect` = 0, `o_redirect_pc` = 0, `o_busy` = 0;
  - `o_ins_stall` = 0;
  - CSR-port outputs equal the pass-through of the `i_ins_*` inputs.
- Trap, with cycle 0 being the IDLE cycle in which the request is sampled:
  - writes occur in cycles 1–3;
  - the `mtvec` read occurs in cycle 4;
  - `o_redirect` is high in cycle 5;
  - IDLE resumes in cycle 6.
- `mret`: `mepc` read in cycle 1, `o_redirect` in cycle 2.
- `o_redirect` is high for exactly one cycle per accepted request.
- `o_redirect_pc` holds its value until the next REDIRECT or reset.

## Configuration
- `TRAP_CTRL_VECTORED_EN`
  - Defined: when `is_irq` = 1 and `mtvec[1:0]` = 2'b01, the trap target is {`mtvec[31:2]`, 2'b00} + 4·cause (32-bit, wraps modulo 2^32). Exceptions always use the base address.
  - Undefined: every trap targets {`mtvec[31:2]`, 2'b00}, and `mtvec[1:0]` is ignored.

## Test plan
- **Exception redirect.** Preload `mtvec` = 0x0000_0100. Pulse `i_exc_valid` with cause 2, pc 0x0000_0040, tval 0xDEAD_BEEF.
  - Required: CSR file ends with `mepc` = 0x40, `mcause` = 0x2, `mtval` = 0xDEADBEEF.
  - Required: `o_redirect` in cycle 5 with `o_redirect_pc` = 0x100.
- **Interrupt redirect.** `mtvec` = 0x0000_0201. Pulse `i_irq_valid` with cause 7, pc 0x80.
  - Required: `mcause` = 0x8000_0007, `mtval` = 0.
  - Required: redirect to 0x21C with `TRAP_CTRL_VECTORED_EN` defined, 0x200 without.
- **`mret`.** `mepc` = 0x0000_1236. Pulse `i_mret`.
  - Required: redirect in cycle 2 to 0x1234.
- **Simultaneous requests.** Exception, interrupt, `mret` and an `i_ins_csr_we` write to 0x340 all in one cycle.
  - Required: only the exception is sequenced, `mcause` = its cause, and no write to 0x340 reaches the CSR port.
- **Busy behaviour.** A second exception arrives in cycle 2 of a trap, and a CSR instruction is presented during the trap.
  - Required: the second exception is ignored and `o_ins_stall` = 1 through cycle 5.
  - Required: once IDLE resumes, the instruction's CSRRS to 0x304 passes through in the same cycle.
- **Reset mid-sequence.** Assert `i_rst` during W_CAUSE.
  - Required: outputs immediately take reset values and `mtval` is unchanged.
  - Required: a later trap completes normally.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences mepc/mcause/mtval writes and the mtvec/mepc redirect.
// Optional macro TRAP_CTRL_VECTORED_EN enables vectored interrupt targets.
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_exc_valid,
    input  logic [3:0]      i_exc_cause,
    input  logic [XLEN-1:0] i_exc_pc,
    input  logic [XLEN-1:0] i_exc_tval,
    input  logic            i_irq_valid,
    input  logic [3:0]      i_irq_cause,
    input  logic [XLEN-1:0] i_irq_pc,
    input  logic            i_mret,
    input  logic            i_ins_csr_we,
    input  logic            i_ins_csr_re,
    input  logic [3:0]      i_ins_funct3,
    input  logic [11:0]     i_ins_csr_addr,
    input  logic [XLEN-1:0] i_ins_csr_wdata,
    output logic            o_ins_stall,
    output logic [11:0]     o_csr_addr,
    output logic            o_csr_we,
    output logic            o_csr_re,
    output logic [3:0]      o_csr_funct3,
    output logic [XLEN-1:0] o_csr_data,
    input  logic [XLEN-1:0] i_csr_rdata,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_TVAL,
        RD_VEC,
        RD_EPC,
        REDIRECT
    } state_t;

    localparam logic [11:0] MTVEC  = 12'h305;
    localparam logic [11:0] MEPC   = 12'h341;
    localparam logic [11:0] MCAUSE = 12'h342;
    localparam logic [11:0] MTVAL  = 12'h343;
    localparam logic [3:0]  CSRRW  = 4'b0001;

    state_t          state;
    state_t          next;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [3:0]      cause_q;
    logic            is_irq_q;

    logic            idle;
    logic            take_exc;
    logic            take_irq;
    logic            take_mret;
    logic            accept;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] target;

    // Requests are gated by reset so the port stays a pure pass-through then.
    assign idle      = (state == IDLE) && !i_rst;
    assign take_exc  = idle && i_exc_valid;
    assign take_irq  = idle && !i_exc_valid && i_irq_valid;
    assign take_mret = idle && !i_exc_valid && !i_irq_valid && i_mret;
    assign accept    = take_exc || take_irq || take_mret;

    assign base = {i_csr_rdata[XLEN-1:2], 2'b00};

    always_comb begin
        target = base;
`ifdef TRAP_CTRL_VECTORED_EN
        if (state == RD_VEC && is_irq_q && i_csr_rdata[1:0] == 2'b01) begin
            target = base + XLEN'({cause_q, 2'b00});
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            pc_q          <= '0;
            tval_q        <= '0;
            cause_q       <= '0;
            is_irq_q      <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state <= next;
            if (take_exc) begin
                pc_q     <= i_exc_pc;
                tval_q   <= i_exc_tval;
                cause_q  <= i_exc_cause;
                is_irq_q <= 1'b0;
            end else if (take_irq) begin
                pc_q     <= i_irq_pc;
                tval_q   <= '0;
                cause_q  <= i_irq_cause;
                is_irq_q <= 1'b1;
            end
            // Loaded on the edge into REDIRECT so the strobe and target align.
            if (state == RD_VEC || state == RD_EPC) begin
                redirect_pc_q <= target;
            end
        end
    end

    always_comb begin
        next         = state;
        o_csr_addr   = '0;
        o_csr_we     = 1'b0;
        o_csr_re     = 1'b0;
        o_csr_funct3 = '0;
        o_csr_data   = '0;
        o_ins_stall  = 1'b1;
        o_redirect   = 1'b0;
        unique case (state)
            IDLE: begin
                if (take_exc || take_irq) begin
                    next = W_EPC;
                end else if (take_mret) begin
                    next = RD_EPC;
                end
                if (!accept) begin
                    o_csr_addr   = i_ins_csr_addr;
                    o_csr_we     = i_ins_csr_we;
                    o_csr_re     = i_ins_csr_re;
                    o_csr_funct3 = i_ins_funct3;
                    o_csr_data   = i_ins_csr_wdata;
                    o_ins_stall  = 1'b0;
                end
            end
            W_EPC: begin
                o_csr_addr   = MEPC;
                o_csr_we     = 1'b1;
                o_csr_funct3 = CSRRW;
                o_csr_data   = {pc_q[XLEN-1:2], 2'b00};
                next         = W_CAUSE;
            end
            W_CAUSE: begin
                o_csr_addr   = MCAUSE;
                o_csr_we     = 1'b1;
                o_csr_funct3 = CSRRW;
                o_csr_data   = {is_irq_q, {(XLEN-5){1'b0}}, cause_q};
                next         = W_TVAL;
            end
            W_TVAL: begin
                o_csr_addr   = MTVAL;
                o_csr_we     = 1'b1;
                o_csr_funct3 = CSRRW;
                o_csr_data   = tval_q;
                next         = RD_VEC;
            end
            RD_VEC: begin
                o_csr_addr = MTVEC;
                o_csr_re   = 1'b1;
                next       = REDIRECT;
            end
            RD_EPC: begin
                o_csr_addr = MEPC;
                o_csr_re   = 1'b1;
                next       = REDIRECT;
            end
            REDIRECT: begin
                o_redirect = 1'b1;
                next       = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    assign o_redirect_pc = redirect_pc_q;
    assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against a
// behavioural CSR file and trap/return reference model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        irq_valid;
    logic [3:0]  irq_cause;
    logic [31:0] irq_pc;
    logic        mret;
    logic        ins_we;
    logic        ins_re;
    logic [3:0]  ins_f3;
    logic [11:0] ins_addr;
    logic [31:0] ins_wdata;
    logic        ins_stall;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic        csr_re;
    logic [3:0]  csr_f3;
    logic [31:0] csr_data;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    int tot = 0;
    int bad = 0;
    int lat;
    int nw;
    logic [31:0] rpc;

    logic [31:0] csr [4096];
    int          wr_cnt = 0;
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(32)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_exc_valid    (exc_valid),
        .i_exc_cause    (exc_cause),
        .i_exc_pc       (exc_pc),
        .i_exc_tval     (exc_tval),
        .i_irq_valid    (irq_valid),
        .i_irq_cause    (irq_cause),
        .i_irq_pc       (irq_pc),
        .i_mret         (mret),
        .i_ins_csr_we   (ins_we),
        .i_ins_csr_re   (ins_re),
        .i_ins_funct3   (ins_f3),
        .i_ins_csr_addr (ins_addr),
        .i_ins_csr_wdata(ins_wdata),
        .o_ins_stall    (ins_stall),
        .o_csr_addr     (csr_addr),
        .o_csr_we       (csr_we),
        .o_csr_re       (csr_re),
        .o_csr_funct3   (csr_f3),
        .o_csr_data     (csr_data),
        .i_csr_rdata    (csr_rdata),
        .o_redirect     (redirect),
        .o_redirect_pc  (redirect_pc),
        .o_busy         (busy)
    );

    // Behavioural CSR file: combinational read, CSRRW/RS/RC write.
    assign csr_rdata = csr[csr_addr];

    always @(posedge clk) begin
        if (pre_we) begin
            csr[pre_addr] <= pre_data;
        end else if (csr_we) begin
            wr_cnt <= wr_cnt + 1;
            case (csr_f3[1:0])
                2'b01: csr[csr_addr] <= csr_data;
                2'b10: csr[csr_addr] <= csr[csr_addr] | csr_data;
                2'b11: csr[csr_addr] <= csr[csr_addr] & ~csr_data;
                default: ;
            endcase
        end
    end

    function automatic logic [31:0] ref_target(input int kind,
                                               input logic [31:0] vec,
                                               input logic [31:0] epc,
                                               input logic [3:0] cause);
        logic [31:0] b;
        if (kind == 2) return (epc >> 2) << 2;
        b = (vec >> 2) << 2;
`ifdef TRAP_CTRL_VECTORED_EN
        if (kind == 1 && vec % 4 == 1) return b + 32'(cause) * 4;
`endif
        return b;
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic clear_inputs();
        exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
        irq_valid = 0; irq_cause = 0; irq_pc = 0; mret = 0;
        ins_we = 0; ins_re = 0; ins_f3 = 0; ins_addr = 0; ins_wdata = 0;
    endtask

    // kind: 0 exception, 1 interrupt, 2 mret. Called at a negedge.
    task automatic run_req(input int kind, input logic [3:0] cause,
                           input logic [31:0] pc, input logic [31:0] tval);
        int w0;
        w0 = wr_cnt;
        case (kind)
            0: begin exc_valid = 1; exc_cause = cause; exc_pc = pc; exc_tval = tval; end
            1: begin irq_valid = 1; irq_cause = cause; irq_pc = pc; end
            default: mret = 1;
        endcase
        #1;
        tot++;
        if ({ins_stall, csr_we, csr_re} !== 3'b100) begin
            bad++;
            $display("FAIL accept_cycle stall/we/re got=%b want=100",
                     {ins_stall, csr_we, csr_re});
        end
        @(negedge clk);
        exc_valid = 0; irq_valid = 0; mret = 0; ins_we = 0; ins_re = 0;
        lat = -1;
        rpc = '0;
        for (int n = 1; n <= 20; n++) begin
            if (redirect === 1'b1) begin
                lat = n;
                rpc = redirect_pc;
                break;
            end
            tot++;
            if (ins_stall !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_stall cycle=%0d got=%b%b want=11", n, busy, ins_stall);
            end
            @(negedge clk);
        end
        @(negedge clk);
        tot++;
        if ({redirect, busy, ins_stall} !== 3'b000 || redirect_pc !== rpc) begin
            bad++;
            $display("FAIL after_redirect rd/busy/stall=%b pc=%h want=000 pc=%h",
                     {redirect, busy, ins_stall}, redirect_pc, rpc);
        end
        nw = wr_cnt - w0;
    endtask

    task automatic test_reset();
        rst = 1;
        exc_valid = 1; exc_cause = 4'h3;
        ins_we = 1; ins_re = 1; ins_f3 = 4'h2; ins_addr = 12'h300; ins_wdata = 32'h1234_5678;
        #1;
        tot++;
        if ({busy, redirect, ins_stall} !== 3'b000 || redirect_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%b pc=%h want=000 pc=0",
                     {busy, redirect, ins_stall}, redirect_pc);
        end
        tot++;
        if (csr_addr !== 12'h300 || csr_we !== 1'b1 || csr_re !== 1'b1 ||
            csr_f3 !== 4'h2 || csr_data !== 32'h1234_5678) begin
            bad++;
            $display("FAIL reset_passthru got=%h %b%b %h %h want=300 11 2 12345678",
                     csr_addr, csr_we, csr_re, csr_f3, csr_data);
        end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_exception();
        preload(12'h305, 32'h0000_0100);
        preload(12'h341, 32'h0);
        preload(12'h342, 32'h0);
        preload(12'h343, 32'h0);
        run_req(0, 4'd2, 32'h0000_0040, 32'hDEAD_BEEF);
        tot++;
        if (lat !== 5 || rpc !== 32'h100) begin
            bad++;
            $display("FAIL exc_redirect lat=%0d pc=%h want=5 pc=00000100", lat, rpc);
        end
        tot++;
        if (csr[12'h341] !== 32'h40 || csr[12'h342] !== 32'h2 ||
            csr[12'h343] !== 32'hDEAD_BEEF || nw !== 3) begin
            bad++;
            $display("FAIL exc_csrs got=%h %h %h n=%0d want=40 2 deadbeef n=3",
                     csr[12'h341], csr[12'h342], csr[12'h343], nw);
        end
    endtask

    task automatic test_interrupt();
        logic [31:0] exp_pc;
        exp_pc = ref_target(1, 32'h0000_0201, 32'h0, 4'd7);
        preload(12'h305, 32'h0000_0201);
        preload(12'h343, 32'h5555_5555);
        run_req(1, 4'd7, 32'h0000_0080, 32'hFFFF_FFFF);
        tot++;
        if (lat !== 5 || rpc !== exp_pc) begin
            bad++;
            $display("FAIL irq_redirect lat=%0d pc=%h want=5 pc=%h", lat, rpc, exp_pc);
        end
        tot++;
        if (csr[12'h342] !== 32'h8000_0007 || csr[12'h343] !== 32'h0 ||
            csr[12'h341] !== 32'h80) begin
            bad++;
            $display("FAIL irq_csrs got=%h %h %h want=80000007 0 80",
                     csr[12'h342], csr[12'h343], csr[12'h341]);
        end
    endtask

    task automatic test_mret();
        preload(12'h341, 32'h0000_1236);
        run_req(2, 4'd0, 32'h0, 32'h0);
        tot++;
        if (lat !== 2 || rpc !== 32'h1234 || nw !== 0) begin
            bad++;
            $display("FAIL mret_redirect lat=%0d pc=%h n=%0d want=2 pc=00001234 n=0",
                     lat, rpc, nw);
        end
    endtask

    task automatic test_simultaneous();
        preload(12'h340, 32'hA5A5_A5A5);
        preload(12'h305, 32'h0000_0400);
        irq_valid = 1; irq_cause = 4'd3; irq_pc = 32'h900;
        ins_we = 1; ins_f3 = 4'h1; ins_addr = 12'h340; ins_wdata = 32'h0;
        run_req(0, 4'hB, 32'h0000_0104, 32'h77);
        tot++;
        if (lat !== 5 || rpc !== 32'h400 || nw !== 3) begin
            bad++;
            $display("FAIL simul_redirect lat=%0d pc=%h n=%0d want=5 pc=00000400 n=3",
                     lat, rpc, nw);
        end
        tot++;
        if (csr[12'h342] !== 32'hB || csr[12'h340] !== 32'hA5A5_A5A5 ||
            csr[12'h343] !== 32'h77) begin
            bad++;
            $display("FAIL simul_csrs mcause=%h mscratch=%h mtval=%h want=b a5a5a5a5 77",
                     csr[12'h342], csr[12'h340], csr[12'h343]);
        end
        clear_inputs();
    endtask

    task automatic test_busy();
        int extra;
        preload(12'h305, 32'h0000_0800);
        preload(12'h304, 32'h0);
        exc_valid = 1; exc_cause = 4'd5; exc_pc = 32'h200; exc_tval = 32'h1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                exc_valid = 0;
                ins_we = 1; ins_re = 1; ins_f3 = 4'h2; ins_addr = 12'h304; ins_wdata = 32'h8;
            end
            if (c == 2) begin
                exc_valid = 1; exc_cause = 4'd9; exc_pc = 32'h300; exc_tval = 32'h2;
            end
            if (c == 3) exc_valid = 0;
            #1;
            if (c <= 5) begin
                tot++;
                if (ins_stall !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_stall_c%0d got=%b want=1", c, ins_stall);
                end
            end
            if (c == 5) begin
                tot++;
                if (redirect !== 1'b1 || redirect_pc !== 32'h800) begin
                    bad++;
                    $display("FAIL busy_redirect got=%b pc=%h want=1 pc=00000800",
                             redirect, redirect_pc);
                end
            end
            if (c == 6) begin
                tot++;
                if (ins_stall !== 1'b0 || csr_addr !== 12'h304 || csr_we !== 1'b1 ||
                    csr_re !== 1'b1 || csr_f3 !== 4'h2 || csr_data !== 32'h8) begin
                    bad++;
                    $display("FAIL busy_passthru stall=%b a=%h we=%b re=%b f3=%h d=%h",
                             ins_stall, csr_addr, csr_we, csr_re, csr_f3, csr_data);
                end
            end
        end
        @(negedge clk);
        clear_inputs();
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            if (redirect === 1'b1 || busy === 1'b1) extra++;
            @(negedge clk);
        end
        tot++;
        if (extra !== 0 || csr[12'h342] !== 32'h5 || csr[12'h341] !== 32'h200 ||
            csr[12'h304] !== 32'h8) begin
            bad++;
            $display("FAIL busy_ignore extra=%0d mcause=%h mepc=%h mie=%h want=0 5 200 8",
                     extra, csr[12'h342], csr[12'h341], csr[12'h304]);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        preload(12'h343, 32'h1357_9BDF);
        preload(12'h342, 32'h0);
        preload(12'h305, 32'h0000_0040);
        exc_valid = 1; exc_cause = 4'd4; exc_pc = 32'h44; exc_tval = 32'h99;
        @(negedge clk);
        exc_valid = 0;
        @(negedge clk);
        tot++;
        if (csr_addr !== 12'h342 || csr_we !== 1'b1) begin
            bad++;
            $display("FAIL mid_wcause a=%h we=%b want=342 1", csr_addr, csr_we);
        end
        rst = 1;
        #1;
        tot++;
        if ({busy, ins_stall, redirect, csr_we, csr_re} !== 5'b0 || redirect_pc !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset flags=%b pc=%h want=00000 pc=0",
                     {busy, ins_stall, redirect, csr_we, csr_re}, redirect_pc);
        end
        @(negedge clk);
        rst = 0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            if (redirect === 1'b1 || busy === 1'b1) extra++;
            @(negedge clk);
        end
        tot++;
        if (extra !== 0 || csr[12'h343] !== 32'h1357_9BDF || csr[12'h342] !== 32'h0) begin
            bad++;
            $display("FAIL mid_abandon extra=%0d mtval=%h mcause=%h want=0 13579bdf 0",
                     extra, csr[12'h343], csr[12'h342]);
        end
        run_req(0, 4'd6, 32'h0000_0050, 32'h60);
        tot++;
        if (lat !== 5 || rpc !== 32'h40 || csr[12'h343] !== 32'h60 || csr[12'h342] !== 32'h6) begin
            bad++;
            $display("FAIL mid_recover lat=%0d pc=%h mtval=%h mcause=%h want=5 40 60 6",
                     lat, rpc, csr[12'h343], csr[12'h342]);
        end
    endtask

    task automatic test_random();
        int          kind;
        logic [31:0] vec, epc, pc, tval, exp_pc;
        logic [31:0] exp_cause;
        logic [3:0]  cause;
        for (int i = 0; i < 24; i++) begin
            kind  = $urandom_range(0, 2);
            vec   = $urandom;
            if ($urandom_range(0, 1) == 1) vec = (vec & 32'hFFFF_FFFC) | 32'h1;
            epc   = $urandom;
            pc    = $urandom;
            tval  = $urandom;
            cause = 4'($urandom_range(0, 15));
            preload(12'h305, vec);
            preload(12'h341, epc);
            preload(12'h343, 32'h0BAD_0000);
            exp_pc = ref_target(kind, vec, epc, cause);
            run_req(kind, cause, pc, tval);
            tot++;
            if (lat !== (kind == 2 ? 2 : 5) || rpc !== exp_pc || nw !== (kind == 2 ? 0 : 3)) begin
                bad++;
                $display("FAIL rand%0d_redirect kind=%0d lat=%0d pc=%h n=%0d want pc=%h",
                         i, kind, lat, rpc, nw, exp_pc);
            end
            exp_cause = (kind == 1 ? 32'h8000_0000 : 32'h0) + 32'(cause);
            tot++;
            if (kind == 2) begin
                if (csr[12'h341] !== epc) begin
                    bad++;
                    $display("FAIL rand%0d_mepc_kept got=%h want=%h", i, csr[12'h341], epc);
                end
            end else if (csr[12'h341] !== (pc >> 2) << 2 || csr[12'h342] !== exp_cause ||
                         csr[12'h343] !== (kind == 1 ? 32'h0 : tval)) begin
                bad++;
                $display("FAIL rand%0d_csrs got=%h %h %h want=%h %h %h", i,
                         csr[12'h341], csr[12'h342], csr[12'h343],
                         (pc >> 2) << 2, exp_cause, (kind == 1 ? 32'h0 : tval));
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_exception();
        test_interrupt();
        test_mret();
        test_simultaneous();
        test_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
